// File: rtl/sample_stream_pkg.sv
// Shared helpers for the sample stream buffer: level width, counter maximum
// and a saturating increment usable for any counter width up to 64 bits.
package sample_stream_pkg;

    // Widest counter the saturating helpers support.
    localparam int unsigned SAT_MAX_WIDTH = 64;

    // All-ones at the widest supported counter width.
    localparam logic [SAT_MAX_WIDTH-1:0] COUNT_MAX_FULL = {SAT_MAX_WIDTH{1'b1}};

    // Width needed to hold an occupancy from 0 up to and including depth.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Largest value a counter of the given width can hold.
    function automatic logic [SAT_MAX_WIDTH-1:0] count_max(input int width);
        return COUNT_MAX_FULL >> (SAT_MAX_WIDTH - width);
    endfunction

    // Increment by one, holding at the maximum for the given width.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
        input logic [SAT_MAX_WIDTH-1:0] value,
        input int                       width
    );
        if (value >= count_max(width)) begin
            return value;
        end else begin
            return value + 64'd1;
        end
    endfunction

endpackage

// File: rtl/sample_stream_ram.sv
// Simple dual-port storage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module sample_stream_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write the incoming word at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sample_stream_buffer.sv
// Ready/valid stream buffer with first-word-fall-through head register,
// registered ready, synchronous flush and saturating statistics counters.
// The RAM holds every buffered word; the head register mirrors the entry at
// rd_ptr so the output is registered, and the entry after it is read
// asynchronously so a pop can refill the head on the same edge.
module sample_stream_buffer
    import sample_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          stream_in_valid,
    output logic                          stream_in_ready,
    input  logic [DATA_WIDTH-1:0]         stream_in_data,
    output logic                          stream_out_valid,
    input  logic                          stream_out_ready,
    output logic [DATA_WIDTH-1:0]         stream_out_data,
    output logic [level_width(DEPTH)-1:0] level,
    output logic [COUNT_WIDTH-1:0]        stall_count,
    output logic [COUNT_WIDTH-1:0]        backpressure_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [LVL_W-1:0]       level_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [COUNT_WIDTH-1:0] stall_count_r;
    logic [COUNT_WIDTH-1:0] backpressure_count_r;

    logic                   push_s;
    logic                   pop_s;
    logic [LVL_W-1:0]       next_level_s;
    logic                   head_valid_s;
    logic [DATA_WIDTH-1:0]  head_data_s;
    logic [DATA_WIDTH-1:0]  ram_rd_data_s;
    logic                   ram_wr_en_s;

    assign push_s      = stream_in_valid && in_ready_r;
    assign pop_s       = out_valid_r && stream_out_ready;
    assign ram_wr_en_s = push_s && !flush && rst_n;

    sample_stream_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (stream_in_data),
        .rd_addr (rd_ptr_r + PTR_W'(1)),
        .rd_data (ram_rd_data_s)
    );

    // Occupancy after this edge, ignoring flush and reset.
    always_comb begin
        next_level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   next_level_s = level_r + LVL_W'(1);
            2'b01:   next_level_s = level_r - LVL_W'(1);
            default: next_level_s = level_r;
        endcase
    end

    // Next head: refill from the following entry on pop, or take the pushed
    // word when the buffer is (or becomes) otherwise empty.
    always_comb begin
        head_valid_s = out_valid_r;
        head_data_s  = out_data_r;
        if (pop_s) begin
            if (level_r > LVL_W'(1)) begin
                head_valid_s = 1'b1;
                head_data_s  = ram_rd_data_s;
            end else if (push_s) begin
                head_valid_s = 1'b1;
                head_data_s  = stream_in_data;
            end else begin
                head_valid_s = 1'b0;
                head_data_s  = out_data_r;
            end
        end else if (push_s && !out_valid_r) begin
            head_valid_s = 1'b1;
            head_data_s  = stream_in_data;
        end else begin
            head_valid_s = out_valid_r;
            head_data_s  = out_data_r;
        end
    end

    // Pointers, occupancy, ready and head stage; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r     <= next_level_s;
            in_ready_r  <= (next_level_s != LEVEL_FULL);
            out_valid_r <= head_valid_s;
            out_data_r  <= head_data_s;
        end
    end

    // Saturating statistics; flush does not touch them, reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_r        <= {COUNT_WIDTH{1'b0}};
            backpressure_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (out_valid_r && !stream_out_ready) begin
                stall_count_r <= COUNT_WIDTH'(sat_inc(64'(stall_count_r), COUNT_WIDTH));
            end
            if (stream_in_valid && !in_ready_r) begin
                backpressure_count_r <= COUNT_WIDTH'(sat_inc(64'(backpressure_count_r), COUNT_WIDTH));
            end
        end
    end

    assign stream_in_ready    = in_ready_r;
    assign stream_out_valid   = out_valid_r;
    assign stream_out_data    = out_data_r;
    assign level              = level_r;
    assign stall_count        = stall_count_r;
    assign backpressure_count = backpressure_count_r;

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Bench for sample_stream_buffer: two configurations (8-bit/depth 4/16-bit
// counters and 128-bit/depth 8/2-bit counters) driven by the same stimulus,
// each checked every cycle against a queue-style model, plus directed
// scenarios with hand-computed expectations.
module tb_sample_stream_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [7:0]   a_out_data;
    logic [2:0]   a_level;
    logic [15:0]  a_stall, a_bp;

    logic         b_in_ready, b_out_valid;
    logic [127:0] b_out_data;
    logic [3:0]   b_level;
    logic [1:0]   b_stall, b_bp;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sample_stream_buffer #(.DATA_WIDTH(8), .DEPTH(4), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .stream_in_valid(in_valid), .stream_in_ready(a_in_ready),
        .stream_in_data(in_data[7:0]),
        .stream_out_valid(a_out_valid), .stream_out_ready(out_ready),
        .stream_out_data(a_out_data), .level(a_level),
        .stall_count(a_stall), .backpressure_count(a_bp)
    );

    sample_stream_buffer #(.DATA_WIDTH(128), .DEPTH(8), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .stream_in_valid(in_valid), .stream_in_ready(b_in_ready),
        .stream_in_data(in_data),
        .stream_out_valid(b_out_valid), .stream_out_ready(out_ready),
        .stream_out_data(b_out_data), .level(b_level),
        .stall_count(b_stall), .backpressure_count(b_bp)
    );

    // Model state: items[0] is the oldest buffered word (the head).
    typedef struct packed {
        logic [15:0][127:0] items;
        logic [4:0]         count;
        logic               ready;
        logic [63:0]        stall;
        logic [63:0]        bp;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mstep(input mstate_t s, input int depth, input int cw,
                                      input logic [127:0] dmask, input logic rst,
                                      input logic fl, input logic iv,
                                      input logic [127:0] id, input logic ordy);
        mstate_t n;
        logic [63:0] cmax;
        logic push, pop;
        n = s;
        cmax = (64'd1 << cw) - 64'd1;
        if (!rst) begin
            n = '0;
        end else begin
            if (iv && !s.ready && s.bp < cmax) n.bp = s.bp + 64'd1;
            if (s.count != 5'd0 && !ordy && s.stall < cmax) n.stall = s.stall + 64'd1;
            if (fl) begin
                n.count = 5'd0;
                n.ready = 1'b0;
            end else begin
                push = iv && s.ready;
                pop  = (s.count != 5'd0) && ordy;
                if (pop) begin
                    for (int k = 0; k < 15; k++) n.items[k] = n.items[k+1];
                    n.count = n.count - 5'd1;
                end
                if (push) begin
                    n.items[n.count] = id & dmask;
                    n.count = n.count + 5'd1;
                end
                n.ready = (n.count != 5'(depth));
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the models on every rising edge with the same inputs the DUTs see.
    always @(posedge clk) begin
        ma <= mstep(ma, 4, 16, 128'hFF, rst_n, flush, in_valid, in_data, out_ready);
        mb <= mstep(mb, 8, 2, {128{1'b1}}, rst_n, flush, in_valid, in_data, out_ready);
    end

    // Compare both DUTs against their models away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_ready", 128'(a_in_ready), 128'(ma.ready));
            chk("a_valid", 128'(a_out_valid), 128'(ma.count != 5'd0));
            chk("a_level", 128'(a_level), 128'(ma.count));
            chk("a_stall", 128'(a_stall), 128'(ma.stall));
            chk("a_bp", 128'(a_bp), 128'(ma.bp));
            if (ma.count != 5'd0) chk("a_data", 128'(a_out_data), ma.items[0]);
            chk("b_ready", 128'(b_in_ready), 128'(mb.ready));
            chk("b_valid", 128'(b_out_valid), 128'(mb.count != 5'd0));
            chk("b_level", 128'(b_level), 128'(mb.count));
            chk("b_stall", 128'(b_stall), 128'(mb.stall));
            chk("b_bp", 128'(b_bp), 128'(mb.bp));
            if (mb.count != 5'd0) chk("b_data", b_out_data, mb.items[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] wide_pat(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i) ^ 32'h0F0F_F0F0, 32'hDEAD_0000 | 32'(i), 32'(i)};
    endfunction

    initial begin
        logic [127:0] exp_w;
        int           ordy_bias;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 128'h55; out_ready = 1'b0;

        // Reset with in_valid high: nothing counts, all outputs zero.
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_ready", 128'(a_in_ready), 128'd0);
        chk("rst_valid", 128'(a_out_valid), 128'd0);
        chk("rst_data", 128'(a_out_data), 128'd0);
        chk("rst_level", 128'(a_level), 128'd0);
        chk("rst_stall", 128'(a_stall), 128'd0);
        chk("rst_bp", 128'(a_bp), 128'd0);

        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("rel_ready", 128'(a_in_ready), 128'd1);
        chk("rel_level", 128'(a_level), 128'd0);

        // Fill depth-4 buffer with the sink stalled, then push into a full buffer.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 128'(8'h11 * i);
            tick();
            if (i == 1) begin
                chk("lat1_valid", 128'(a_out_valid), 128'd1);
                chk("lat1_data", 128'(a_out_data), 128'h11);
            end
        end
        chk("full_level", 128'(a_level), 128'd4);
        chk("full_ready", 128'(a_in_ready), 128'd0);
        chk("full_head", 128'(a_out_data), 128'h11);
        in_data = 128'h55;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        chk("bp_count", 128'(a_bp), 128'd3);
        chk("stall_count", 128'(a_stall), 128'd7);
        chk("b_stall_sat", 128'(b_stall), 128'd3);

        // One pop from full.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_head", 128'(a_out_data), 128'h22);
        chk("pop_level", 128'(a_level), 128'd3);
        chk("pop_ready", 128'(a_in_ready), 128'd1);

        // Flush with a simultaneous push of 0xAA.
        flush = 1'b1; in_valid = 1'b1; in_data = 128'hAA;
        tick();
        chk("fl_level", 128'(a_level), 128'd0);
        chk("fl_valid", 128'(a_out_valid), 128'd0);
        chk("fl_ready", 128'(a_in_ready), 128'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_ready_back", 128'(a_in_ready), 128'd1);
        in_valid = 1'b1; in_data = 128'h5A;
        tick();
        in_valid = 1'b0;
        chk("fl_push_valid", 128'(a_out_valid), 128'd1);
        chk("fl_push_data", 128'(a_out_data), 128'h5A);
        chk("fl_push_level", 128'(a_level), 128'd1);
        out_ready = 1'b1;
        tick();

        // Continuous stream: level holds at 1, each word is the head one edge later.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = wide_pat(i);
            tick();
            exp_w = wide_pat(i);
            chk("str_a_level", 128'(a_level), 128'd1);
            chk("str_b_level", 128'(b_level), 128'd1);
            chk("str_b_data", b_out_data, exp_w);
            chk("str_a_data", 128'(a_out_data), 128'(exp_w[7:0]));
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of buffered data.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 128'(i + 8'h70);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_level", 128'(a_level), 128'd0);
        chk("mid_rst_valid", 128'(a_out_valid), 128'd0);
        chk("mid_rst_data", 128'(a_out_data), 128'd0);
        chk("mid_rst_stall", 128'(a_stall), 128'd0);
        chk("mid_rst_b_level", 128'(b_level), 128'd0);
        chk("mid_rst_b_data", b_out_data, 128'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Randomized traffic with occasional flush and reset.
        ordy_bias = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) ordy_bias = $urandom_range(0, 4);
            rst_n     = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) < ordy_bias);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
